omp_iter_sched: RTL and testbench
=================================

# omp_iter_sched

Iteration scheduler for the 8x8 OMP reconstruction core. It accepts the system start pulse and run configuration, then sequences the correlation, atom-selection, least-squares and residual-update engines through up to K iterations using start/done pulse handshakes. It records the chosen atom indices in the support memory and finally triggers the pixel output stage. It sits directly under the system top, between the start/config inputs and the datapath engines, and owns `done_all`.

## Interface
- `TIMEOUT`, 16'hFFFF: maximum number of cycles a stage may run before `done` arrives.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `start_system`  in  1  run request pulse.
- `N_in`  in  6  dictionary size minus 1 (63 for 8x8).
- `M_in`  in  3  measurement configuration; passed through to engines.
- `K_limit`  in  5  requested iteration count.
- `corr_start`/`sel_start`/`ls_start`/`res_start`/`out_start`  out  1 each  one-cycle stage start pulses.
- `corr_done`/`sel_done`/`ls_done`/`res_done`/`out_done`  in  1 each  one-cycle stage completion pulses.
- `sel_idx`  in  6  selected atom index; valid with `sel_done`.
- `sel_dup`  in  1  selected atom is already in the support; valid with `sel_done`.
- `res_below`  in  1  residual is below threshold; valid with `res_done`.
- `cfg_N`  out  6  latched `N_in`.
- `cfg_M`  out  3  latched `M_in`.
- `supp_we`  out  1  support memory write strobe.
- `supp_addr`  out  5  support slot; equals the current iteration.
- `supp_data`  out  6  atom index to write.
- `k_used`  out  5  number of atoms committed so far.
- `busy`  out  1  run in progress.
- `done_all`  out  1  one-cycle end-of-run pulse.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, CORR, SEL, LS, RES, OUT.
- **IDLE + `start_system`**
  - Latch `cfg_N`, `cfg_M`, and K_eff = min(`K_limit`, `N_in`+1), compared at 7-bit width.
  - Clear `k_used` and `err`.
  - If K_eff=0: go to OUT and pulse `out_start`. Otherwise go to CORR and pulse `corr_start`.
- `start_system` outside IDLE is ignored.
- **CORR + `corr_done`**: go to SEL and pulse `sel_start`.
- **SEL + `sel_done`**
  - If `sel_dup`=1: go to OUT and pulse `out_start`. No support write.
  - Otherwise: pulse `supp_we` with `supp_addr`=`k_used` and `supp_data`=`sel_idx`. In the same cycle, pulse `ls_start` and go to LS.
- **LS + `ls_done`**: go to RES and pulse `res_start`.
- **RES + `res_done`**
  - `k_used` <= `k_used`+1.
  - If (`k_used`+1 == K_eff) or `res_below`: go to OUT and pulse `out_start`.
  - Otherwise: go to CORR and pulse `corr_start`.
- **OUT + `out_done`**: pulse `done_all` and go to IDLE.
- A `done` input not belonging to the current state is ignored. This includes a `done` asserted in the same cycle as its own start pulse.
- **Watchdog**
  - 16-bit counter, cleared on every stage entry and incremented each cycle in CORR, SEL, LS, RES and OUT.
  - On reaching `TIMEOUT` with no matching `done`: set `err`=1, pulse `done_all`, go to IDLE.
- `err` stays at 1 until the next accepted start.
- `busy`=1 in every state except IDLE.

## Timing
- Reset value of every output is 0. The internal state is IDLE, and K_eff and the watchdog are 0.
- All outputs are registered.
- Start pulse: high exactly 1 cycle, in the cycle after the accepting edge (the accepting edge is the `start_system` edge or the previous stage's `done` edge).
- `supp_we`/`supp_addr`/`supp_data` are asserted in the same cycle as `ls_start`.
- `done_all` is high 1 cycle, the cycle after the `out_done` edge. `busy` falls in that same cycle.
- Controller overhead is 1 cycle per stage transition. Each iteration costs 4 stage latencies + 4 cycles.
- `rst_n`=0 mid-run:
  - Next edge returns to IDLE with all outputs 0 and no `done_all`.
  - `done` pulses arriving during or after reset are ignored.
- Simultaneous `res_done` and `res_below` on the last iteration: a single transition to OUT.

## Test plan
- **Nominal run.** Stimulus: `N_in`=63, `M_in`=7, `K_limit`=8; engines return `done` 3 cycles after each start, with `sel_idx`=iteration*5. Required: 8 support writes to addr 0..7 with data 0,5,..,35; one `out_start`; `done_all` once; `k_used`=8; `err`=0.
- **Early stop.** Stimulus: `K_limit`=8, with `res_below`=1 on the 3rd `res_done`. Required: `out_start` follows that `res_done` by 1 cycle; `k_used`=3; no 4th `corr_start`.
- **Duplicate atom and K=0.** Stimulus: `sel_dup`=1 on the 2nd `sel_done`. Required: 1 support write, `k_used`=1, OUT entered. Separately, `K_limit`=0 must give `out_start` 1 cycle after start with no `corr_start`.
- **Clamp and ignored start.** Stimulus: `N_in`=3, `K_limit`=31. Required: exactly 4 iterations. A `start_system` during the run changes nothing.
- **Timeout.** Stimulus: `TIMEOUT`=20 and `ls_done` withheld. Required: `err`=1 and a `done_all` pulse 20 cycles after LS entry; back in IDLE. The next start clears `err`.
- **Reset mid-run and stray done.** Stimulus: `rst_n`=0 for 1 cycle while in RES, then `res_done`. Required: all outputs 0, state IDLE, no `done_all`, and the late `res_done` is ignored.

Source files
------------

// File: rtl/omp_iter_sched_if.sv
// Engine-side handshake bundle for the OMP iteration scheduler.
// Latency: none (wires only).
// Backpressure: none; stages use one-cycle start/done pulses, no stalls.
//
// Ports carried: five stage start pulses, five stage done pulses, the
// atom-selection results, the residual flag and the support-memory write port.
// master = scheduler side, slave = engine/memory side.
interface omp_iter_sched_if;
    logic       corr_start;
    logic       sel_start;
    logic       ls_start;
    logic       res_start;
    logic       out_start;
    logic       corr_done;
    logic       sel_done;
    logic       ls_done;
    logic       res_done;
    logic       out_done;
    logic [5:0] sel_idx;
    logic       sel_dup;
    logic       res_below;
    logic       supp_we;
    logic [4:0] supp_addr;
    logic [5:0] supp_data;

    modport master (
        output corr_start, sel_start, ls_start, res_start, out_start,
        output supp_we, supp_addr, supp_data,
        input  corr_done, sel_done, ls_done, res_done, out_done,
        input  sel_idx, sel_dup, res_below
    );

    modport slave (
        input  corr_start, sel_start, ls_start, res_start, out_start,
        input  supp_we, supp_addr, supp_data,
        output corr_done, sel_done, ls_done, res_done, out_done,
        output sel_idx, sel_dup, res_below
    );
endinterface

// File: rtl/omp_iter_sched.sv
// Iteration scheduler: sequences CORR/SEL/LS/RES for up to K_eff iterations, then OUT.
// Latency: 1 cycle from an accepted start/done edge to the next registered start pulse.
// Backpressure: none; stages hand back via done pulses, a watchdog aborts hung stages.
//
// Ports: clk, rst_n (sync active-low); start_system/N_in/M_in/K_limit run request;
// eng (master) carries stage start/done pulses and the support write port;
// cfg_N/cfg_M latched config, k_used atoms committed, busy, done_all pulse, err sticky.
module omp_iter_sched #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_system,
    input  logic [5:0]              N_in,
    input  logic [2:0]              M_in,
    input  logic [4:0]              K_limit,
    omp_iter_sched_if.master        eng,
    output logic [5:0]              cfg_N,
    output logic [2:0]              cfg_M,
    output logic [4:0]              k_used,
    output logic                    busy,
    output logic                    done_all,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CORR = 3'd1,
        S_SEL  = 3'd2,
        S_LS   = 3'd3,
        S_RES  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  k_eff, k_eff_nxt;
    logic [15:0] wdog, wdog_nxt;

    logic        corr_start_nxt, sel_start_nxt, ls_start_nxt, res_start_nxt, out_start_nxt;
    logic        supp_we_nxt;
    logic [4:0]  supp_addr_nxt;
    logic [5:0]  supp_data_nxt;
    logic [5:0]  cfg_N_nxt;
    logic [2:0]  cfg_M_nxt;
    logic [4:0]  k_used_nxt;
    logic        busy_nxt, done_all_nxt, err_nxt;

    logic        go;
    logic        corr_acc, sel_acc, ls_acc, res_acc, out_acc, stage_acc;
    logic        tmo, res_last, entering;
    logic [6:0]  k_req7, dict7;
    logic [4:0]  k_eff_new;

    // A done is only taken in its own state, and never in the cycle its start
    // pulse is still high (the registered start doubles as the mask).
    assign go        = (state == S_IDLE) && start_system;
    assign corr_acc  = (state == S_CORR) && eng.corr_done && !eng.corr_start;
    assign sel_acc   = (state == S_SEL)  && eng.sel_done  && !eng.sel_start;
    assign ls_acc    = (state == S_LS)   && eng.ls_done   && !eng.ls_start;
    assign res_acc   = (state == S_RES)  && eng.res_done  && !eng.res_start;
    assign out_acc   = (state == S_OUT)  && eng.out_done  && !eng.out_start;
    assign stage_acc = corr_acc | sel_acc | ls_acc | res_acc | out_acc;

    // The watchdog fires on the edge where it would reach TIMEOUT; a done
    // arriving on that same edge still wins.
    assign tmo = (state != S_IDLE) && !stage_acc && (wdog == TIMEOUT - 16'd1);

    // K_eff = min(K_limit, N_in+1) at 7 bits so N_in=63 does not wrap.
    // The result never exceeds K_limit, so 5 bits hold it.
    assign k_req7    = {2'b00, K_limit};
    assign dict7     = {1'b0, N_in} + 7'd1;
    assign k_eff_new = (k_req7 < dict7) ? K_limit : dict7[4:0];

    assign res_last  = (({1'b0, k_used} + 6'd1) == {1'b0, k_eff});
    assign entering  = (state_nxt != state);

    // State register: state plus every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            k_eff          <= '0;
            wdog           <= '0;
            eng.corr_start <= 1'b0;
            eng.sel_start  <= 1'b0;
            eng.ls_start   <= 1'b0;
            eng.res_start  <= 1'b0;
            eng.out_start  <= 1'b0;
            eng.supp_we    <= 1'b0;
            eng.supp_addr  <= '0;
            eng.supp_data  <= '0;
            cfg_N          <= '0;
            cfg_M          <= '0;
            k_used         <= '0;
            busy           <= 1'b0;
            done_all       <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            k_eff          <= k_eff_nxt;
            wdog           <= wdog_nxt;
            eng.corr_start <= corr_start_nxt;
            eng.sel_start  <= sel_start_nxt;
            eng.ls_start   <= ls_start_nxt;
            eng.res_start  <= res_start_nxt;
            eng.out_start  <= out_start_nxt;
            eng.supp_we    <= supp_we_nxt;
            eng.supp_addr  <= supp_addr_nxt;
            eng.supp_data  <= supp_data_nxt;
            cfg_N          <= cfg_N_nxt;
            cfg_M          <= cfg_M_nxt;
            k_used         <= k_used_nxt;
            busy           <= busy_nxt;
            done_all       <= done_all_nxt;
            err            <= err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (go)       state_nxt = (k_eff_new == 5'd0) ? S_OUT : S_CORR;
            S_CORR: if (corr_acc) state_nxt = S_SEL;
            S_SEL:  if (sel_acc)  state_nxt = eng.sel_dup ? S_OUT : S_LS;
            S_LS:   if (ls_acc)   state_nxt = S_RES;
            S_RES:  if (res_acc)  state_nxt = (res_last || eng.res_below) ? S_OUT : S_CORR;
            S_OUT:  if (out_acc)  state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
        if (tmo) begin
            state_nxt = S_IDLE;
        end
    end

    // Output logic: next values for the registered outputs. Every transition
    // changes state, so "entering X" is exactly the start pulse for stage X.
    always_comb begin
        corr_start_nxt = entering && (state_nxt == S_CORR);
        sel_start_nxt  = entering && (state_nxt == S_SEL);
        ls_start_nxt   = entering && (state_nxt == S_LS);
        res_start_nxt  = entering && (state_nxt == S_RES);
        out_start_nxt  = entering && (state_nxt == S_OUT);

        // LS is only ever entered from a non-duplicate selection.
        supp_we_nxt    = ls_start_nxt;
        supp_addr_nxt  = ls_start_nxt ? k_used : 5'd0;
        supp_data_nxt  = ls_start_nxt ? eng.sel_idx : 6'd0;

        cfg_N_nxt      = go ? N_in : cfg_N;
        cfg_M_nxt      = go ? M_in : cfg_M;
        k_eff_nxt      = go ? k_eff_new : k_eff;

        k_used_nxt     = k_used;
        if (go) begin
            k_used_nxt = 5'd0;
        end else if (res_acc) begin
            k_used_nxt = k_used + 5'd1;
        end

        err_nxt        = err;
        if (go) begin
            err_nxt = 1'b0;
        end else if (tmo) begin
            err_nxt = 1'b1;
        end

        done_all_nxt   = out_acc || tmo;
        busy_nxt       = (state_nxt != S_IDLE);

        wdog_nxt       = wdog;
        if (entering) begin
            wdog_nxt = 16'd0;
        end else if (state != S_IDLE) begin
            wdog_nxt = wdog + 16'd1;
        end
    end

endmodule

// File: tb/tb_omp_iter_sched.sv
// Bench for omp_iter_sched: scripted engines answer each start pulse after a
// random delay; expectations come from a per-run iteration model (K_eff clamp,
// duplicate/early-stop exits) plus pulse totals from a free-running monitor.
module tb_omp_iter_sched;
    localparam logic [15:0] TMO = 16'd20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_system;
    logic [5:0] N_in;
    logic [2:0] M_in;
    logic [4:0] K_limit;
    logic [5:0] cfg_N;
    logic [2:0] cfg_M;
    logic [4:0] k_used;
    logic       busy;
    logic       done_all;
    logic       err;

    omp_iter_sched_if eng ();

    omp_iter_sched #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_system (start_system),
        .N_in         (N_in),
        .M_in         (M_in),
        .K_limit      (K_limit),
        .eng          (eng),
        .cfg_N        (cfg_N),
        .cfg_M        (cfg_M),
        .k_used       (k_used),
        .busy         (busy),
        .done_all     (done_all),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Running pulse totals, sampled mid-cycle.
    int tot_corr = 0, tot_out = 0, tot_we = 0, tot_done = 0;
    always @(negedge clk) begin
        if (eng.corr_start) tot_corr <= tot_corr + 1;
        if (eng.out_start)  tot_out  <= tot_out + 1;
        if (eng.supp_we)    tot_we   <= tot_we + 1;
        if (done_all)       tot_done <= tot_done + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input int s, input logic v);
        case (s)
            0: eng.corr_done = v;
            1: eng.sel_done  = v;
            2: eng.ls_done   = v;
            3: eng.res_done  = v;
            default: eng.out_done = v;
        endcase
    endtask

    task automatic clr_dones;
        for (int s = 0; s < 5; s++) set_done(s, 1'b0);
    endtask

    // Idle d cycles before the real done. The first cycle carries noise: a done
    // of another stage and, when still in the start cycle, possibly our own.
    task automatic wait_stage(input int own, input int d, input bit own_junk);
        for (int i = 0; i < d; i++) begin
            if (i == 0) begin
                if (own_junk) set_done(own, 1'($urandom_range(0, 1)));
                set_done((own + 1 + int'($urandom_range(0, 3))) % 5, 1'b1);
            end
            tick;
            clr_dones;
        end
    endtask

    task automatic fire(input int own);
        set_done(own, 1'b1);
        tick;
        clr_dones;
    endtask

    task automatic do_start(input logic [5:0] n, input logic [2:0] m, input logic [4:0] kl);
        N_in = n; M_in = m; K_limit = kl;
        start_system = 1'b1;
        tick;
        start_system = 1'b0;
    endtask

    // One full run. below_at/dup_at are 1-based iteration numbers (0 = never).
    task automatic run(input logic [5:0] n, input logic [2:0] m, input logic [4:0] kl,
                       input int below_at, input int dup_at, input bit stray, input bit fixed_idx);
        int keff, it, kexp, c0, o0, w0, d0, exp_corr, exp_we;
        bit fin;
        logic [5:0] idx;
        keff = (int'(kl) < int'(n) + 1) ? int'(kl) : int'(n) + 1;
        c0 = tot_corr; o0 = tot_out; w0 = tot_we; d0 = tot_done;
        kexp = 0; exp_corr = 0; exp_we = 0;
        do_start(n, m, kl);
        chk("cfg_N", int'(cfg_N), int'(n));
        chk("cfg_M", int'(cfg_M), int'(m));
        chk("busy_run", int'(busy), 1);
        chk("err_cleared", int'(err), 0);
        chk("k_used_clear", int'(k_used), 0);
        if (keff == 0) begin
            chk("k0_out_start", int'(eng.out_start), 1);
            chk("k0_no_corr", int'(eng.corr_start), 0);
        end else begin
            it = 0; fin = 0;
            while (!fin) begin
                chk("corr_start", int'(eng.corr_start), 1);
                exp_corr++;
                if (stray && it == 0) begin
                    start_system = 1'b1; N_in = n ^ 6'h15; K_limit = kl ^ 5'h07;
                    tick;
                    start_system = 1'b0; N_in = n; K_limit = kl;
                    wait_stage(0, int'($urandom_range(1, 3)), 1'b0);
                end else begin
                    wait_stage(0, int'($urandom_range(1, 4)), 1'b1);
                end
                fire(0);
                chk("sel_start", int'(eng.sel_start), 1);
                wait_stage(1, int'($urandom_range(1, 4)), 1'b1);
                idx = fixed_idx ? 6'(it * 5) : 6'($urandom_range(0, 63));
                eng.sel_idx = idx;
                eng.sel_dup = (it + 1 == dup_at);
                fire(1);
                eng.sel_idx = '0; eng.sel_dup = 1'b0;
                if (it + 1 == dup_at) begin
                    chk("dup_out_start", int'(eng.out_start), 1);
                    chk("dup_no_we", int'(eng.supp_we), 0);
                    fin = 1;
                end else begin
                    chk("ls_start", int'(eng.ls_start), 1);
                    chk("supp_we", int'(eng.supp_we), 1);
                    chk("supp_addr", int'(eng.supp_addr), it);
                    chk("supp_data", int'(eng.supp_data), int'(idx));
                    exp_we++;
                    wait_stage(2, int'($urandom_range(1, 4)), 1'b1);
                    fire(2);
                    chk("res_start", int'(eng.res_start), 1);
                    wait_stage(3, int'($urandom_range(1, 4)), 1'b1);
                    eng.res_below = (it + 1 == below_at);
                    fire(3);
                    eng.res_below = 1'b0;
                    kexp = it + 1;
                    chk("k_used_inc", int'(k_used), kexp);
                    if (kexp == keff || it + 1 == below_at) begin
                        chk("end_out_start", int'(eng.out_start), 1);
                        chk("end_no_corr", int'(eng.corr_start), 0);
                        fin = 1;
                    end
                    it++;
                end
            end
        end
        wait_stage(4, int'($urandom_range(1, 4)), 1'b1);
        fire(4);
        chk("done_all", int'(done_all), 1);
        chk("busy_fall", int'(busy), 0);
        chk("k_used_final", int'(k_used), kexp);
        chk("err_final", int'(err), 0);
        chk("cfg_N_held", int'(cfg_N), int'(n));
        tick;
        chk("done_all_1cyc", int'(done_all), 0);
        chk("n_corr_start", tot_corr - c0, exp_corr);
        chk("n_supp_we", tot_we - w0, exp_we);
        chk("n_out_start", tot_out - o0, 1);
        chk("n_done_all", tot_done - d0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done_all"}, int'(done_all), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_k_used"}, int'(k_used), 0);
        chk({tag, "_cfg"}, int'({cfg_N, cfg_M}), 0);
        chk({tag, "_starts"}, int'({eng.corr_start, eng.sel_start, eng.ls_start,
                                    eng.res_start, eng.out_start}), 0);
        chk({tag, "_supp"}, int'({eng.supp_we, eng.supp_addr, eng.supp_data}), 0);
    endtask

    initial begin
        int seen, c0, d0;
        rst_n = 1'b0; start_system = 1'b0;
        N_in = '0; M_in = '0; K_limit = '0;
        eng.sel_idx = '0; eng.sel_dup = 1'b0; eng.res_below = 1'b0;
        clr_dones;
        tick; tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick; tick;
        chk("idle_busy", int'(busy), 0);

        // Nominal, early stop, duplicate, K=0, clamp with stray start.
        run(6'd63, 3'd7, 5'd8, 0, 0, 1'b0, 1'b1);
        run(6'd63, 3'd7, 5'd8, 3, 0, 1'b0, 1'b0);
        run(6'd63, 3'd2, 5'd8, 0, 2, 1'b0, 1'b0);
        run(6'd63, 3'd1, 5'd0, 0, 0, 1'b0, 1'b0);
        run(6'd3,  3'd5, 5'd31, 0, 0, 1'b1, 1'b0);

        // Watchdog: withhold ls_done.
        do_start(6'd63, 3'd7, 5'd8);
        chk("tmo_corr_start", int'(eng.corr_start), 1);
        wait_stage(0, 2, 1'b0); fire(0);
        chk("tmo_sel_start", int'(eng.sel_start), 1);
        wait_stage(1, 2, 1'b0);
        eng.sel_idx = 6'd9; fire(1); eng.sel_idx = '0;
        chk("tmo_ls_start", int'(eng.ls_start), 1);
        seen = 0;
        for (int i = 1; i <= 24; i++) begin
            tick;
            if (done_all) begin seen = i; break; end
        end
        chk("tmo_done_all_cycle", seen, int'(TMO));
        chk("tmo_err", int'(err), 1);
        chk("tmo_busy", int'(busy), 0);
        tick; tick;
        chk("tmo_done_all_1cyc", int'(done_all), 0);
        chk("tmo_err_sticky", int'(err), 1);
        run(6'd63, 3'd7, 5'd2, 0, 0, 1'b0, 1'b0);

        // Reset in RES of the second iteration, with res_done during and after.
        do_start(6'd63, 3'd7, 5'd8);
        for (int k = 0; k < 2; k++) begin
            wait_stage(0, 2, 1'b0); fire(0);
            wait_stage(1, 2, 1'b0);
            eng.sel_idx = 6'(k + 1); fire(1); eng.sel_idx = '0;
            wait_stage(2, 2, 1'b0); fire(2);
            chk("rst_res_start", int'(eng.res_start), 1);
            if (k == 0) begin
                wait_stage(3, 2, 1'b0); fire(3);
            end
        end
        chk("rst_k_used_pre", int'(k_used), 1);
        tick;
        c0 = tot_corr; d0 = tot_done;
        rst_n = 1'b0; eng.res_done = 1'b1;
        tick;
        rst_n = 1'b1;
        chk_all_zero("midrst");
        tick;
        eng.res_done = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        chk_all_zero("post_rst");
        chk("post_rst_no_done_all", tot_done - d0, 0);
        chk("post_rst_no_corr", tot_corr - c0, 0);

        // Randomised runs over the whole config space.
        for (int r = 0; r < 10; r++) begin
            run(($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 12)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
